// File: rtl/uart_tx_sched.sv
// Two-source UART transmitter: round-robin arbitration between req0/req1, then
// a start / 8 data (LSB first) / stop frame timed by an integer baud divider.
module uart_tx_sched #(
    parameter int CLK_HZ = 1036800,
    parameter int BAUD   = 115200
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic       uart_tx,
    output logic       busy,
    output logic       grant_id
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_sched: CLK_HZ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       idx, idx_nx;
    logic [7:0]       shreg, shreg_nx;
    logic             tx_q, tx_nx;
    logic             grant_q, grant_nx;
    logic             last_q, last_nx;

    logic sel_vld;
    logic sel;
    logic take;

    // Arbitration: a lone requester always wins; contention alternates.
    assign sel_vld = req0_valid | req1_valid;
    assign sel     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign take    = (state == IDLE) && rst && sel_vld;

    assign req0_ready = take && !sel;
    assign req1_ready = take && sel;
    assign uart_tx    = tx_q;
    assign busy       = (state != IDLE);
    assign grant_id   = grant_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        tx_nx    = tx_q;
        grant_nx = grant_q;
        last_nx  = last_q;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nx = START;
                    cnt_nx   = CNT_RLD;
                    tx_nx    = 1'b0;
                    grant_nx = sel;
                    last_nx  = sel;
                    shreg_nx = sel ? req1_data : req0_data;
                end
            end
            START: begin
                if (cnt == '0) begin
                    state_nx = DATA;
                    cnt_nx   = CNT_RLD;
                    idx_nx   = 3'd0;
                    tx_nx    = shreg[0];
                    shreg_nx = {1'b0, shreg[7:1]};
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_nx = CNT_RLD;
                    if (idx == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        tx_nx    = shreg[0];
                        shreg_nx = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control state; reset drops tx high immediately and abandons the frame.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            tx_q    <= 1'b1;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            tx_q    <= tx_nx;
            grant_q <= grant_nx;
            last_q  <= last_nx;
        end
    end

    // Data byte only; it is reloaded on every acceptance.
    always_ff @(posedge clk25) begin
        shreg <= shreg_nx;
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched at the default 9 clocks per bit.
module tb_uart_tx_sched;

    logic       clk;
    logic       rst;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic       uart_tx, busy, grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    uart_tx_sched dut (
        .clk25      (clk),
        .rst        (rst),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d0;
        logic       v0;
        logic [7:0] d1;
        logic       v1;
        logic       r0;
        logic       r1;
        logic       gid;
        logic [7:0] byte_exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Starts just after the acceptance edge; samples every cycle of the frame.
    task automatic check_frame(input logic [7:0] b, input logic g, input string nm);
        int   tx_err = 0;
        int   bz_err = 0;
        int   rd_err = 0;
        int   slot;
        logic exp;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            slot = k / 9;
            if (slot == 0)      exp = 1'b0;
            else if (slot == 9) exp = 1'b1;
            else                exp = b[slot-1];
            if (uart_tx !== exp) tx_err++;
            if (busy !== 1'b1) bz_err++;
            if (req0_ready || req1_ready) rd_err++;
        end
        check({nm, "_tx_bit_errors"}, tx_err, 0);
        check({nm, "_busy_errors"}, bz_err, 0);
        check({nm, "_ready_during_frame"}, rd_err, 0);
        check({nm, "_grant_id"}, grant_id, g);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (t == 200) check({nm, "_idle_timeout"}, 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int n0, n1, t, who, prev, nacc, nfall;
        int acc_t[2];
        int fall_t[2];
        logic prev_tx;

        vecs[0] = '{8'hA5, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C};
        vecs[2] = '{8'h81, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
        vecs[3] = '{8'h55, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA};
        vecs[4] = '{8'h12, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[5] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[6] = '{8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF};
        vecs[7] = '{8'h0F, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F};

        rst        = 1'b0;
        req0_data  = 8'h5A;
        req1_data  = 8'hC3;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_readies", {req0_ready, req1_ready}, 0);
        do_reset();

        // Table-driven frames; order matters because of round-robin history.
        for (int i = 0; i < 8; i++) begin
            req0_data  = vecs[i].d0;
            req0_valid = vecs[i].v0;
            req1_data  = vecs[i].d1;
            req1_valid = vecs[i].v1;
            @(negedge clk);
            check($sformatf("vec%0d_busy_idle", i), busy, 0);
            check($sformatf("vec%0d_readies", i), {req0_ready, req1_ready},
                  {vecs[i].r0, vecs[i].r1});
            @(posedge clk);
            #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            if (vecs[i].r0 || vecs[i].r1) begin
                check_frame(vecs[i].byte_exp, vecs[i].gid, $sformatf("vec%0d", i));
            end else begin
                @(negedge clk);
                check($sformatf("vec%0d_no_start", i), busy, 0);
                check($sformatf("vec%0d_grant_hold", i), grant_id, vecs[i].gid);
                @(posedge clk);
                #1;
            end
        end

        // Contention straight after reset: req0 first, req1 exactly 91 cycles later.
        do_reset();
        req0_data  = 8'h11;
        req1_data  = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("cont_first_readies", {req0_ready, req1_ready}, 2'b10);
        n0 = cyc;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check_frame(8'h11, 1'b0, "cont_f0");
        n1 = -1;
        for (t = 0; t < 20; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            if (req1_ready) begin
                n1 = cyc;
                break;
            end
        end
        check("cont_second_gap", n1 - n0, 91);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        check_frame(8'h22, 1'b1, "cont_f1");

        // Fairness: both held for six frames.
        req0_data  = 8'h01;
        req1_data  = 8'h02;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            who = -1;
            for (t = 0; t < 200; t++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    who = req1_ready ? 1 : 0;
                    break;
                end
            end
            check($sformatf("fair_both_ready_%0d", i), req0_ready & req1_ready, 0);
            check($sformatf("fair_grant_%0d", i), who, i % 2);
            check($sformatf("fair_no_repeat_%0d", i), (who == prev), 0);
            prev = who;
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("fair");

        // Single source streaming 0x00 then 0xFF on req1.
        req1_data  = 8'h00;
        req1_valid = 1'b1;
        nacc    = 0;
        nfall   = 0;
        prev_tx = 1'b1;
        acc_t   = '{0, 0};
        fall_t  = '{0, 0};
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (prev_tx && !uart_tx && nfall < 2) begin
                fall_t[nfall] = cyc;
                nfall++;
            end
            prev_tx = uart_tx;
            if (req1_ready && nacc < 2) begin
                acc_t[nacc] = cyc;
                nacc++;
            end
            @(posedge clk);
            #1;
            if (nacc == 1) req1_data = 8'hFF;
            if (nacc == 2) req1_valid = 1'b0;
        end
        check("stream_acc_count", nacc, 2);
        check("stream_acc_gap", acc_t[1] - acc_t[0], 91);
        check("stream_fall_count", nfall, 2);
        check("stream_fall_gap", fall_t[1] - fall_t[0], 91);
        wait_idle("stream");

        // Inputs changing during a frame must not disturb it.
        req0_data  = 8'hC3;
        req0_valid = 1'b1;
        @(negedge clk);
        check("ign_ready0", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        fork
            check_frame(8'hC3, 1'b0, "ign");
            begin
                repeat (20) @(posedge clk);
                #1;
                req0_data = 8'h3C;
                repeat (20) @(posedge clk);
                #1;
                req1_data  = 8'h99;
                req1_valid = 1'b1;
                @(posedge clk);
                #1;
                req1_valid = 1'b0;
                req0_data  = 8'hFF;
            end
        join
        @(negedge clk);
        check("ign_pulse_not_sent", busy, 0);
        @(posedge clk);
        #1;

        // Reset during data bit 3, then req0 must win the next contention.
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        @(negedge clk);
        check("mid_ready0", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_pre_rst_tx", uart_tx, 0);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_tx", uart_tx, 1);
        check("mid_rst_busy", busy, 0);
        req0_data  = 8'h33;
        req1_data  = 8'h44;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mid_rst_readies", {req0_ready, req1_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_after_readies", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_frame(8'h33, 1'b0, "mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares the single system UART transmit line between two byte sources: req0 (CPU I/O register) and req1 (monitor/boot status path).
- Arbitrates round-robin, then sequences the serial frame itself: start bit, 8 data bits LSB first, one stop bit.
- Sits between the requesters and the uart_tx pin of the system top level.
- Bit timing is derived from the system clock by an integer divider.

Parameters:
- CLK_HZ, 1036800 (9*115200): system clock frequency in Hz.
- BAUD, 115200: serial bit rate.
- DIV, CLK_HZ/BAUD (derived localparam): clock cycles per bit. Must be >= 2; a smaller value is an elaboration error.

Ports:
- clk25  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = in reset).
- req0_data  in  8  byte offered by requester 0.
- req0_valid  in  1  requester 0 has a byte.
- req0_ready  out  1  requester 0 byte is accepted this cycle.
- req1_data  in  8  byte offered by requester 1.
- req1_valid  in  1  requester 1 has a byte.
- req1_ready  out  1  requester 1 byte is accepted this cycle.
- uart_tx  out  1  serial line; idles high.
- busy  out  1  frame in progress (state != IDLE).
- grant_id  out  1  requester whose byte is (or was last) being sent.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, uart_tx=1, busy=0, grant_id=0.
  - last_grant=1, so req0 wins the first contention.
  - Bit counter and baud counter = 0; both readies = 0.
  - Reset asserted mid-frame aborts the frame immediately: uart_tx returns high without waiting for a clock, and the partial byte is discarded.
- States: IDLE, START, DATA, STOP.
- Arbitration (combinational, IDLE only):
  - Only one valid -> that requester is selected.
  - Both valid -> select !last_grant.
  - Neither valid -> no selection.
  - reqN_ready = (state==IDLE) && rst && selected==N. At most one ready is high in any cycle.
- Handshake:
  - A transfer occurs on a clock edge where reqN_valid && reqN_ready.
  - On that edge: shift register <= reqN_data, grant_id <= N, last_grant <= N, baud counter <= DIV-1, state <= START.
  - Requesters hold data and valid until ready. The scheduler does not depend on valid being held: a requester that drops valid before acceptance simply loses its turn.
- Output timing, for an acceptance at edge E:
  - uart_tx = 0 for DIV cycles starting at E.
  - Then 8 data bits, bit0 first, DIV cycles each.
  - Then stop bit = 1 for DIV cycles.
  - Total frame: 10*DIV cycles (90 at defaults).
- Baud counter:
  - Decrements each cycle; the bit period ends when it reaches 0, and it reloads DIV-1 on each bit advance.
  - DATA keeps a 3-bit index; it leaves DATA after index 7 completes.
  - uart_tx is a registered output: no glitches and no combinational path from the inputs.
- End of frame: at the end of the stop bit, state -> IDLE and busy=0. The earliest next acceptance is that first IDLE cycle, so the back-to-back frame period is 10*DIV+1 cycles (91 at defaults).
- Inputs during a frame:
  - Valid inputs during START/DATA/STOP are ignored; both readies stay 0.
  - reqN_data changes after acceptance do not affect the frame in flight.
- grant_id holds its value while IDLE.

Test Plan:
- Single byte: after reset, req0_data=0xA5, req0_valid=1 -> req0_ready=1 in the same cycle.
  - uart_tx: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each held exactly 9 cycles; 90 cycles in total.
  - busy=1 for those 90 cycles; grant_id=0.
- Contention: req0 (0x11) and req1 (0x22) both valid from the first cycle after reset -> 0x11 sent first.
  - req1_ready stays 0 throughout the first frame.
  - 0x22 is accepted exactly 91 cycles after the first acceptance; grant_id=1.
- Fairness: both requesters hold valid for 6 frames -> grant order 0,1,0,1,0,1; no requester is granted twice in a row.
- Single source streaming: only req1 valid continuously with 0x00, then 0xFF -> acceptances 91 cycles apart; start-bit falling edges also 91 cycles apart.
- Reset mid-frame: assert rst=0 during data bit 3 -> uart_tx=1 and busy=0 before the next clock edge.
  - After release, with both valid, req0 is granted first.
- Ignored inputs: toggle req0_data during a frame, and pulse req1_valid for 1 cycle mid-frame -> transmitted bits are unchanged and the pulsed byte is never accepted.
